// File: rtl/ddr_arb_pkg.sv
// Shared types and the round-robin helper for the DDR port arbiter.
package ddr_arb_pkg;

  localparam int unsigned DDR_WORD_W = 128;
  localparam int unsigned MAX_REQ    = 8;
  localparam int unsigned MAX_REQ_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WCMD  = 2'd2,
    RCMD  = 2'd3
  } arb_state_t;

  // First set bit of valid searching upward from last+1, wrapping at nreq.
  function automatic logic [MAX_REQ_W-1:0] rr_pick(input logic [MAX_REQ-1:0]   valid,
                                                   input logic [MAX_REQ_W-1:0] last,
                                                   input int unsigned          nreq);
    logic [MAX_REQ_W-1:0] pick;
    logic                 found;
    int unsigned          idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      if (i <= nreq) begin
        idx = (32'(last) + i) % nreq;
        if (!found && valid[idx[MAX_REQ_W-1:0]]) begin
          pick  = idx[MAX_REQ_W-1:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ddr_arb_tag_fifo.sv
// In-order FIFO of requester tags for outstanding read bursts; push and pop may coincide.
module ddr_arb_tag_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 16
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         push_i,
  input  logic [W-1:0] push_tag_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q] <= push_tag_i;
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin sharing of one DDR2 controller front-end among NREQ requesters,
// one burst command per grant, with tag-routed in-order read returns.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned AW          = 28,
  parameter int unsigned BURST_WORDS = 2,
  parameter int unsigned TAG_DEPTH   = 16
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0]              req_read,
  input  logic [NREQ*AW-1:0]           req_addr,
  input  logic [NREQ*DDR_WORD_W-1:0]   req_wdata,
  output logic [NREQ-1:0]              req_wnext,
  output logic [NREQ-1:0]              req_ready,
  output logic [NREQ-1:0]              rd_valid,
  output logic [DDR_WORD_W-1:0]        rd_data,
  output logic                         orphan_err,
  output logic [AW-1:0]                Address,
  output logic                         Read,
  output logic                         WriteAF,
  input  logic                         AFfull,
  output logic [DDR_WORD_W-1:0]        WriteData,
  output logic                         WriteWB,
  input  logic                         WBfull,
  input  logic [DDR_WORD_W-1:0]        ReadData,
  input  logic                         RBempty,
  output logic                         ReadRB
);

  localparam int unsigned GW = $clog2(NREQ);
  localparam int unsigned BW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

  arb_state_t            state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_q, last_d;
  logic [BW-1:0]         wcnt_q, wcnt_d;
  logic [BW-1:0]         rcnt_q, rcnt_d;
  logic [NREQ-1:0]       rd_valid_q;
  logic [DDR_WORD_W-1:0] rd_data_q;
  logic                  orphan_q;

  logic [GW-1:0]         pick;
  logic [NREQ-1:0]       grant_oh;
  logic [AW-1:0]         addr_sel;
  logic [DDR_WORD_W-1:0] wdata_sel;
  logic                  tag_push, tag_pop, tag_empty, tag_full;
  logic [GW-1:0]         tag_head;
  logic [NREQ-1:0]       tag_oh;
  logic                  rb_take;

  assign pick = GW'(rr_pick(MAX_REQ'(req_valid), MAX_REQ_W'(last_q), NREQ));

  // Per-requester slices selected by the registered grant.
  always_comb begin
    grant_oh  = '0;
    addr_sel  = '0;
    wdata_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (GW'(i) == grant_q) begin
        grant_oh[i] = 1'b1;
        addr_sel    = req_addr[i*AW +: AW];
        wdata_sel   = req_wdata[i*DDR_WORD_W +: DDR_WORD_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wcnt_d    = wcnt_q;
    WriteWB   = 1'b0;
    WriteData = '0;
    WriteAF   = 1'b0;
    Read      = 1'b0;
    Address   = '0;
    req_wnext = '0;
    req_ready = '0;
    tag_push  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = pick;
          last_d  = pick;
          state_d = req_read[pick] ? RCMD : WDATA;
        end
      end
      WDATA: begin
        WriteWB   = !WBfull;
        WriteData = wdata_sel;
        if (WriteWB) begin
          req_wnext = grant_oh;
          if (wcnt_q == BW'(BURST_WORDS - 1)) begin
            wcnt_d  = '0;
            state_d = WCMD;
          end else begin
            wcnt_d = wcnt_q + BW'(1);
          end
        end
      end
      WCMD: begin
        WriteAF = !AFfull;
        Address = addr_sel;
        if (WriteAF) begin
          req_ready = grant_oh;
          state_d   = IDLE;
        end
      end
      RCMD: begin
        // A full tag FIFO holds the read command back rather than losing its route.
        WriteAF = !AFfull && !tag_full;
        Read    = 1'b1;
        Address = addr_sel;
        if (WriteAF) begin
          tag_push  = 1'b1;
          req_ready = grant_oh;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Return path: drain the read buffer only while a tag names the owner.
  assign rb_take = !RBempty && !tag_empty;
  assign ReadRB  = rb_take;
  assign tag_pop = rb_take && (rcnt_q == BW'(BURST_WORDS - 1));
  assign tag_oh  = NREQ'(1) << tag_head;

  always_comb begin
    rcnt_d = rcnt_q;
    if (rb_take) rcnt_d = tag_pop ? '0 : rcnt_q + BW'(1);
  end

  ddr_arb_tag_fifo #(
    .W     (GW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .CLK        (CLK),
    .Reset      (Reset),
    .push_i     (tag_push),
    .push_tag_i (grant_q),
    .pop_i      (tag_pop),
    .head_o     (tag_head),
    .empty_o    (tag_empty),
    .full_o     (tag_full)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= GW'(NREQ - 1);
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      rd_valid_q <= rb_take ? tag_oh : '0;
      if (rb_take) rd_data_q <= ReadData;
      if (!RBempty && tag_empty) orphan_q <= 1'b1;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign orphan_err = orphan_q;

endmodule
